// File: rtl/fifo_sr_writer_if.sv
// Purpose: bundle of the producer handshake, FIFO write port, FIFO read-release
//          vector and status signals seen by fifo_sr_writer.
// Signals:
//   in_valid   [FLUX]            producer valid, one bit per flux
//   in_data    [FLUX*DATA_WIDTH] producer payloads, flux f at [f*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   [FLUX]            producer ready, one bit per flux
//   full       [1]               shared FIFO full
//   write      [1]               shared FIFO write strobe
//   din        [WIDTH]           shared FIFO write data, {tag, data}
//   rd_release [FLUX]            one-hot FIFO read vector (word of flux f leaves)
//   occ        [FLUX*CNT_WIDTH]  per-flux outstanding word count
//   err        [1]               sticky protocol error
interface fifo_sr_writer_if #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FLUX         = 2,
    parameter int unsigned MAX_PER_FLUX = 3
);
    localparam int unsigned TAG_WIDTH = $clog2(FLUX);
    localparam int unsigned WIDTH     = DATA_WIDTH + TAG_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(MAX_PER_FLUX + 1);

    logic [FLUX-1:0]            in_valid;
    logic [FLUX*DATA_WIDTH-1:0] in_data;
    logic [FLUX-1:0]            in_ready;
    logic                       full;
    logic                       write;
    logic [WIDTH-1:0]           din;
    logic [FLUX-1:0]            rd_release;
    logic [FLUX*CNT_WIDTH-1:0]  occ;
    logic                       err;

    // Environment side: producers plus the shared FIFO.
    modport master (
        output in_valid, in_data, full, rd_release,
        input  in_ready, write, din, occ, err
    );

    // Writer side.
    modport slave (
        input  in_valid, in_data, full, rd_release,
        output in_ready, write, din, occ, err
    );
endinterface

// File: rtl/fifo_sr_writer.sv
// Purpose: write-side front end of the shared-memory multi-flux FIFO. Holds one
//          word per flux, round-robin arbitrates among fluxes that are below
//          their occupancy cap, and writes {tag, data} into the shared FIFO.
//          Per-flux occupancy is tracked from the FIFO's one-hot read vector.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (reset the FIFO in the same cycle)
//   bus  fifo_sr_writer_if.slave: producer handshake, FIFO write port,
//        read-release vector, occupancy and sticky error
module fifo_sr_writer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUX         = 2,
    parameter int unsigned MAX_PER_FLUX = 3
) (
    input  logic            clk,
    input  logic            rst,
    fifo_sr_writer_if.slave bus
);
    localparam int unsigned TAG_WIDTH = $clog2(FLUX);
    localparam int unsigned CNT_WIDTH = $clog2(MAX_PER_FLUX + 1);

    if (FLUX < 2 || MAX_PER_FLUX < 1 || MAX_PER_FLUX > DEPTH) begin : g_param_chk
        $error("fifo_sr_writer: need FLUX>=2 and 1<=MAX_PER_FLUX<=DEPTH");
    end

    logic                  r_hold_valid [FLUX];
    logic [DATA_WIDTH-1:0] r_hold_data  [FLUX];
    logic [CNT_WIDTH-1:0]  r_cnt        [FLUX];
    logic [TAG_WIDTH-1:0]  r_last_grant;
    logic                  r_err;

    logic [FLUX-1:0]       w_elig;
    logic [FLUX-1:0]       w_inc;
    logic [FLUX-1:0]       w_underflow;
    logic                  w_multi;
    logic                  w_grant_vld;
    logic [TAG_WIDTH-1:0]  w_grant;
    logic [TAG_WIDTH-1:0]  w_idx;

    // Round-robin search starting after the last granted flux; the modulo keeps
    // the index inside 0..FLUX-1 for non-power-of-two FLUX.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        if (!rst && !bus.full) begin
            for (int unsigned k = 1; k <= FLUX; k++) begin
                w_idx = TAG_WIDTH'((32'(r_last_grant) + k) % FLUX);
                if (!w_grant_vld && w_elig[w_idx]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = w_idx;
                end
            end
        end
    end

    assign bus.write = w_grant_vld;
    assign bus.din   = w_grant_vld ? {w_grant, r_hold_data[w_grant]} : '0;
    assign bus.err   = r_err;

    // More than one release bit set in a cycle.
    assign w_multi = (bus.rd_release & (bus.rd_release - FLUX'(1))) != '0;

    for (genvar gi = 0; gi < FLUX; gi++) begin : g_flux
        localparam logic [TAG_WIDTH-1:0] IDX = TAG_WIDTH'(gi);

        assign w_elig[gi]      = r_hold_valid[gi] && (r_cnt[gi] < CNT_WIDTH'(MAX_PER_FLUX));
        assign w_inc[gi]       = w_grant_vld && (w_grant == IDX);
        // A release with nothing outstanding is only legal if the same word is
        // being written this cycle (net zero).
        assign w_underflow[gi] = bus.rd_release[gi] && !w_inc[gi] && (r_cnt[gi] == '0);
        // Granted flux may refill in the same cycle for full throughput.
        assign bus.in_ready[gi] = !rst && (!r_hold_valid[gi] || w_inc[gi]);
        assign bus.occ[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt[gi];

        // Per-flux holding register and outstanding counter.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_hold_valid[gi] <= 1'b0;
                r_cnt[gi]        <= '0;
            end else begin
                if (bus.in_valid[gi] && bus.in_ready[gi]) begin
                    r_hold_valid[gi] <= 1'b1;
                    r_hold_data[gi]  <= bus.in_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end else if (w_inc[gi]) begin
                    r_hold_valid[gi] <= 1'b0;
                end
                if (w_inc[gi] && !bus.rd_release[gi]) begin
                    r_cnt[gi] <= r_cnt[gi] + CNT_WIDTH'(1);
                end else if (bus.rd_release[gi] && !w_inc[gi] && (r_cnt[gi] != '0)) begin
                    r_cnt[gi] <= r_cnt[gi] - CNT_WIDTH'(1);
                end
            end
        end
    end

    // Arbitration pointer and sticky error; FLUX-1 at reset gives flux 0 first turn.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= TAG_WIDTH'(FLUX - 1);
            r_err        <= 1'b0;
        end else begin
            if (w_grant_vld) begin
                r_last_grant <= w_grant;
            end
            if ((|w_underflow) || w_multi) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fifo_sr_writer.sv
// Purpose: self-checking bench for fifo_sr_writer (FLUX=2, DATA_WIDTH=8,
//          DEPTH=4, MAX_PER_FLUX=3): directed scenarios followed by random
//          traffic, all compared against a behavioural model each cycle.
module tb_fifo_sr_writer;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned FLUX  = 2;
    localparam int unsigned MAXP  = 3;

    logic clk;
    logic rst;

    fifo_sr_writer_if #(.DATA_WIDTH(DW), .FLUX(FLUX), .MAX_PER_FLUX(MAXP)) bus ();

    fifo_sr_writer #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .FLUX        (FLUX),
        .MAX_PER_FLUX(MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: held word per flux, outstanding counts, pointer, error.
    bit m_hv   [FLUX];
    int m_data [FLUX];
    int m_cnt  [FLUX];
    int m_last;
    bit m_err;

    // Values observed in the most recent cycle, for directed constant checks.
    logic       obs_write;
    logic [9:0] obs_din;
    logic [1:0] obs_rdy;
    logic [3:0] obs_occ;
    logic       obs_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(FLUX); i++) begin
            m_hv[i]  = 1'b0;
            m_cnt[i] = 0;
        end
        m_last = FLUX - 1;
        m_err  = 1'b0;
    endtask

    // One clock: drive at negedge, check outputs against the model, then
    // advance the model across the following posedge.
    task automatic cycle(input bit r, input logic [1:0] v, input logic [15:0] d,
                         input bit fl, input logic [1:0] rel);
        bit         wr;
        int         g;
        logic [9:0] e_din;
        logic [1:0] e_rdy;
        logic [3:0] e_occ;
        @(negedge clk);
        rst            = r;
        bus.in_valid   = v;
        bus.in_data    = d;
        bus.full       = fl;
        bus.rd_release = rel;
        #1;
        wr = 1'b0;
        g  = 0;
        if (!r && !fl) begin
            for (int k = 1; k <= int'(FLUX); k++) begin
                int c;
                c = (m_last + k) % FLUX;
                if (!wr && m_hv[c] && m_cnt[c] < int'(MAXP)) begin
                    wr = 1'b1;
                    g  = c;
                end
            end
        end
        e_din = wr ? 10'(g * 256 + m_data[g]) : 10'd0;
        for (int i = 0; i < int'(FLUX); i++)
            e_rdy[i] = !r && (!m_hv[i] || (wr && g == i));
        e_occ = 4'(m_cnt[1] * 4 + m_cnt[0]);

        obs_write = bus.write;
        obs_din   = bus.din;
        obs_rdy   = bus.in_ready;
        obs_occ   = bus.occ;
        obs_err   = bus.err;
        chk("write",    32'(obs_write), 32'(wr));
        chk("din",      32'(obs_din),   32'(e_din));
        chk("in_ready", 32'(obs_rdy),   32'(e_rdy));
        chk("occ",      32'(obs_occ),   32'(e_occ));
        chk("err",      32'(obs_err),   32'(m_err));

        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < int'(FLUX); i++) begin
                bit inc;
                inc = wr && (g == i);
                if (inc && !rel[i]) m_cnt[i]++;
                else if (rel[i] && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1'b1;
                    else m_cnt[i]--;
                end
            end
            if ($countones(rel) > 1) m_err = 1'b1;
            if (wr) begin
                m_hv[g] = 1'b0;
                m_last  = g;
            end
            for (int i = 0; i < int'(FLUX); i++) begin
                if (v[i] && e_rdy[i]) begin
                    m_hv[i]   = 1'b1;
                    m_data[i] = int'(d[i*DW +: DW]);
                end
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 2'b00, 16'h0000, 1'b0, 2'b00);
    endtask

    task automatic do_reset();
        cycle(1'b1, 2'b00, 16'h0000, 1'b0, 2'b00);
    endtask

    initial begin
        int nwr;
        rst            = 1'b1;
        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.full       = 1'b0;
        bus.rd_release = '0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state.
        idle();
        chk("rst_write", 32'(obs_write), 32'd0);
        chk("rst_occ",   32'(obs_occ),   32'd0);
        chk("rst_err",   32'(obs_err),   32'd0);
        chk("rst_rdy",   32'(obs_rdy),   32'h3);

        // Both fluxes held: two back-to-back writes, flux 0 first.
        cycle(1'b0, 2'b11, 16'h2211, 1'b0, 2'b00);
        idle();
        chk("rr_first",  32'(obs_din), 32'h011);
        idle();
        chk("rr_second", 32'(obs_din), 32'h122);
        idle();
        chk("rr_occ",    32'(obs_occ), 32'h5);

        // Flux 1 streams against its cap of 3, then one release buys one write.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'b10, 16'(($urandom & 8'hff) << 8), 1'b0, 2'b00);
        chk("cap_write", 32'(obs_write),  32'd0);
        chk("cap_rdy1",  32'(obs_rdy[1]), 32'd0);
        chk("cap_occ",   32'(obs_occ),    32'hc);
        nwr = 0;
        cycle(1'b0, 2'b10, 16'h5500, 1'b0, 2'b10);
        nwr += int'(obs_write);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 2'b10, 16'h6600, 1'b0, 2'b00);
            nwr += int'(obs_write);
        end
        chk("cap_release_writes", 32'(nwr), 32'd1);

        // Full stalls everything; afterwards flux 0 goes first with its data intact.
        do_reset();
        cycle(1'b0, 2'b11, 16'hbbaa, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 2'b11, 16'h1234, 1'b1, 2'b00);
            chk("full_write", 32'(obs_write), 32'd0);
            chk("full_rdy",   32'(obs_rdy),   32'd0);
        end
        idle();
        chk("full_after0", 32'(obs_din), 32'h0aa);
        idle();
        chk("full_after1", 32'(obs_din), 32'h1bb);

        // Same-cycle write and release of flux 0 at cnt0=2.
        do_reset();
        cycle(1'b0, 2'b01, 16'h0001, 1'b0, 2'b00);
        cycle(1'b0, 2'b01, 16'h0002, 1'b0, 2'b00);
        cycle(1'b0, 2'b01, 16'h0003, 1'b0, 2'b00);
        cycle(1'b0, 2'b00, 16'h0000, 1'b0, 2'b01);
        chk("wr_rel_write", 32'(obs_din), 32'h003);
        idle();
        chk("wr_rel_occ", 32'(obs_occ), 32'h2);
        chk("wr_rel_err", 32'(obs_err), 32'd0);

        // Release underflow, then a non-one-hot release; err sticky until reset.
        do_reset();
        cycle(1'b0, 2'b00, 16'h0000, 1'b0, 2'b01);
        chk("err_pre", 32'(obs_err), 32'd0);
        cycle(1'b0, 2'b00, 16'h0000, 1'b0, 2'b11);
        chk("err_set", 32'(obs_err), 32'd1);
        idle();
        idle();
        chk("err_sticky", 32'(obs_err), 32'd1);
        do_reset();
        idle();
        chk("err_clr", 32'(obs_err), 32'd0);

        // Reset with both fluxes held and counts 2,1.
        do_reset();
        cycle(1'b0, 2'b11, 16'h2211, 1'b0, 2'b00);
        cycle(1'b0, 2'b01, 16'h0033, 1'b0, 2'b00);
        idle();
        cycle(1'b0, 2'b10, 16'h4400, 1'b0, 2'b00);
        cycle(1'b0, 2'b01, 16'h0055, 1'b1, 2'b00);
        do_reset();
        chk("midrst_occ_before", 32'(obs_occ), 32'h6);
        idle();
        chk("midrst_write", 32'(obs_write), 32'd0);
        chk("midrst_occ",   32'(obs_occ),   32'd0);
        chk("midrst_rdy",   32'(obs_rdy),   32'h3);
        cycle(1'b0, 2'b11, 16'h7766, 1'b0, 2'b00);
        idle();
        chk("midrst_first", 32'(obs_din), 32'h066);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit         r;
            bit         fl;
            logic [1:0] rel;
            r   = ($urandom_range(0, 63) == 0);
            fl  = ($urandom_range(0, 4) == 0);
            rel = ($urandom_range(0, 9) < 3) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle(r, 2'($urandom), 16'($urandom), fl, rel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
